// File: rtl/fir_sample_ring_if.sv
// rtl/fir_sample_ring_if.sv - write/read/status bundle for the multi-channel FIR sample ring
interface fir_sample_ring_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_CH = 2
);
    logic                     clear_i;
    logic                     wvalid_i;
    logic [NUM_CH*DATA_W-1:0] wdata_i;
    logic                     rd_req_i;
    logic [ADDR_W-1:0]        rd_tap_i;
    logic [NUM_CH*DATA_W-1:0] rd_data_o;
    logic                     rd_valid_o;
    logic [ADDR_W:0]          fill_o;
    logic                     full_o;

    modport master (
        output clear_i, wvalid_i, wdata_i, rd_req_i, rd_tap_i,
        input  rd_data_o, rd_valid_o, fill_o, full_o
    );

    modport slave (
        input  clear_i, wvalid_i, wdata_i, rd_req_i, rd_tap_i,
        output rd_data_o, rd_valid_o, fill_o, full_o
    );
endinterface

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - per-channel circular sample buffer addressed by tap age, 1-cycle reads
// Optional FIR_RING_BYPASS_EN: same-cycle reads see the post-write state (tap 0 forwards wdata).
module fir_sample_ring #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_CH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fir_sample_ring_if.slave   bus
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]        r_wptr;
    logic [ADDR_W:0]          r_fill;
    logic                     r_rd_valid;
    logic                     r_zero;
    logic                     w_wr;
    logic                     w_rd;
    logic [ADDR_W:0]          w_fill_inc;
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_zero;
    logic [NUM_CH*DATA_W-1:0] w_rd_data;

    assign w_wr       = bus.wvalid_i & ~bus.clear_i;
    assign w_rd       = bus.rd_req_i & ~bus.clear_i;
    assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + (ADDR_W+1)'(1);

`ifdef FIR_RING_BYPASS_EN
    logic w_fwd;
    logic r_fwd;

    // With a write in flight, every tap shifts one slot toward the new sample.
    assign w_fwd  = w_wr && (bus.rd_tap_i == '0);
    assign w_addr = w_wr ? (r_wptr - bus.rd_tap_i) : (r_wptr - ADDR_W'(1) - bus.rd_tap_i);
    assign w_zero = {1'b0, bus.rd_tap_i} >= (w_wr ? w_fill_inc : r_fill);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fwd <= 1'b0;
        end else if (w_rd) begin
            r_fwd <= w_fwd;
        end
    end
`else
    assign w_addr = r_wptr - ADDR_W'(1) - bus.rd_tap_i;
    assign w_zero = {1'b0, bus.rd_tap_i} >= r_fill;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_fill     <= '0;
            r_rd_valid <= 1'b0;
            r_zero     <= 1'b1;
        end else if (bus.clear_i) begin
            r_wptr     <= '0;
            r_fill     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + ADDR_W'(1);
                r_fill <= w_fill_inc;
            end
            r_rd_valid <= bus.rd_req_i;
            if (bus.rd_req_i) begin
                r_zero <= w_zero;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_q;

        // Read-first: a read of the slot being overwritten returns the oldest sample.
        always_ff @(posedge clk_i) begin
            if (w_wr) begin
                r_mem[r_wptr] <= bus.wdata_i[c*DATA_W +: DATA_W];
            end
            if (w_rd) begin
                r_q <= r_mem[w_addr];
            end
        end

`ifdef FIR_RING_BYPASS_EN
        logic [DATA_W-1:0] r_fwd_q;

        always_ff @(posedge clk_i) begin
            if (w_rd) begin
                r_fwd_q <= bus.wdata_i[c*DATA_W +: DATA_W];
            end
        end

        assign w_rd_data[c*DATA_W +: DATA_W] = r_zero ? '0 : (r_fwd ? r_fwd_q : r_q);
`else
        assign w_rd_data[c*DATA_W +: DATA_W] = r_zero ? '0 : r_q;
`endif
    end

    assign bus.rd_data_o  = w_rd_data;
    assign bus.rd_valid_o = r_rd_valid;
    assign bus.fill_o     = r_fill;
    assign bus.full_o     = (r_fill == FILL_MAX);
endmodule

// File: tb/tb_fir_sample_ring.sv
// tb/tb_fir_sample_ring.sv - scoreboard bench for fir_sample_ring (depth 4, two channels)
module tb_fir_sample_ring;
    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int NC    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_sample_ring_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) bus ();

    fir_sample_ring #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [NC*DW-1:0] hist [$];
    logic [NC*DW-1:0] exp_q [$];
    bit               exp_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit clr, input bit wv, input logic [NC*DW-1:0] wd,
                        input bit rq, input int tap);
        int               fill_m;
        logic [NC*DW-1:0] e;
        rst          = r;
        bus.clear_i  = clr;
        bus.wvalid_i = wv;
        bus.wdata_i  = wd;
        bus.rd_req_i = rq;
        bus.rd_tap_i = AW'(tap);
        fill_m       = hist.size();
        if (r || clr) begin
            hist.delete();
            exp_valid = 1'b0;
        end else begin
            if (rq) begin
                e = '0;
`ifdef FIR_RING_BYPASS_EN
                if (wv) begin
                    if (tap == 0) e = wd;
                    else if (tap - 1 < fill_m) e = hist[tap-1];
                end else if (tap < fill_m) begin
                    e = hist[tap];
                end
`else
                if (tap < fill_m) e = hist[tap];
`endif
                exp_q.push_back(e);
            end
            exp_valid = rq;
            if (wv) begin
                hist.push_front(wd);
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 64'(bus.rd_valid_o), 64'(exp_valid));
        if (exp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.rd_valid_o) chk("rd_data", 64'(bus.rd_data_o), 64'(e));
        end
        chk("fill", 64'(bus.fill_o), 64'(hist.size()));
        chk("full", 64'(bus.full_o), 64'(hist.size() == DEPTH));
    endtask

    function automatic logic [NC*DW-1:0] pk(input int a, input int b);
        return {DW'(b), DW'(a)};
    endfunction

    task automatic wr(input logic [NC*DW-1:0] d);  step(0, 0, 1, d, 0, 0); endtask
    task automatic rd(input int t);                step(0, 0, 0, '0, 1, t); endtask
    task automatic idle();                         step(0, 0, 0, '0, 0, 0); endtask
    task automatic clr();                          step(0, 1, 0, '0, 0, 0); endtask

    initial begin
        step(1, 0, 0, '0, 1, 0);
        step(1, 0, 0, '0, 1, 0);
        chk("rst_data", 64'(bus.rd_data_o), 64'd0);
        rd(0);
        idle();

        wr(pk(10, 20));
        wr(pk(11, 21));
        wr(pk(12, 22));
        for (int t = 0; t < 4; t++) rd(t);
        idle();

        clr();
        for (int v = 1; v <= 6; v++) wr(pk(v, 0));
        for (int t = 0; t < 4; t++) rd(t);
        idle();

        clr();
        wr(pk(5, 50));
        wr(pk(7, 70));
        step(0, 0, 1, pk(9, 90), 1, 0);
        step(0, 0, 1, pk(3, 30), 1, 3);
        rd(0);
        idle();

        clr();
        wr(pk(1, 2));
        wr(pk(3, 4));
        wr(pk(5, 6));
        step(0, 1, 1, pk(99, 99), 1, 0);
        wr(pk(42, 142));
        rd(0);
        rd(1);
        idle();

        step(0, 0, 1, pk(8, 80), 1, 0);
        step(1, 0, 0, '0, 1, 0);
        chk("rst_mid_data", 64'(bus.rd_data_o), 64'd0);

        for (int i = 0; i < 60; i++) begin
            step(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                 pk($urandom_range(0, 65535), $urandom_range(0, 65535)),
                 $urandom_range(0, 1), $urandom_range(0, DEPTH - 1));
        end
        idle();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
